// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to IMEM under credit
// control, buffers returned words in order, and flushes/redirects on branch.
module ifetch_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] INITIAL_IA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_ia,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   output logic        ir_valid,
   output logic [31:0] ir,
   output logic [31:0] ia_plus_4,
   input  logic        ir_ready,
   output logic        err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_ia;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] rq_wr;
   logic [AW-1:0] rq_rd;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;

   logic [31:0] q_ir    [DEPTH];
   logic [31:0] q_iap4  [DEPTH];
   logic [31:0] rq_addr [DEPTH];

   logic        accept;
   logic        resp_ok;
   logic        spurious;
   logic        push;
   logic        pop;
   logic [CW:0] used;
   logic        unused_ia_lsbs;

   assign unused_ia_lsbs = ^redirect_ia[1:0];

   // Credit check, handshake decode and head presentation
   always_comb begin
      used      = {1'b0, occupancy} + {1'b0, outstanding};
      req_valid = (used < DEPTH_EXT) && !redirect_valid && !rst;
      req_addr  = fetch_ia;
      accept    = req_valid && req_ready;
      resp_ok   = resp_valid && (outstanding != '0);
      spurious  = resp_valid && (outstanding == '0);
      push      = resp_ok && (discard == '0) && !redirect_valid;
      ir_valid  = (occupancy != '0);
      pop       = ir_valid && ir_ready && !redirect_valid;
      ir        = ir_valid ? q_ir[head]   : '0;
      ia_plus_4 = ir_valid ? q_iap4[head] : '0;
   end

   // Control state; redirect flushes the queue but keeps in-flight requests tracked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_ia    <= INITIAL_IA;
         head        <= '0;
         tail        <= '0;
         rq_wr       <= '0;
         rq_rd       <= '0;
         occupancy   <= '0;
         outstanding <= '0;
         discard     <= '0;
         err         <= 1'b0;
      end else begin
         if (spurious) err <= 1'b1;

         case ({accept, resp_ok})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase

         if (accept)  rq_wr <= rq_wr + AW'(1);
         if (resp_ok) rq_rd <= rq_rd + AW'(1);

         if (redirect_valid) begin
            fetch_ia  <= {redirect_ia[31:2], 2'b00};
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            discard   <= outstanding - CW'(resp_ok);
         end else begin
            if (accept) fetch_ia <= fetch_ia + 32'd4;
            if (resp_ok && (discard != '0)) discard <= discard - CW'(1);
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
               2'b10:   occupancy <= occupancy + CW'(1);
               2'b01:   occupancy <= occupancy - CW'(1);
               default: occupancy <= occupancy;
            endcase
         end
      end
   end

   // Storage arrays; writes only happen with reset released
   always_ff @(posedge clk) begin
      if (push) begin
         q_ir[tail]   <= resp_data;
         q_iap4[tail] <= rq_addr[rq_rd] + 32'd4;
      end
      if (accept) rq_addr[rq_wr] <= fetch_ia;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a latency-configurable IMEM model
// and an in-order consumer scoreboard.
module tb_ifetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_ia;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        ir_valid;
   logic [31:0] ir;
   logic [31:0] ia_plus_4;
   logic        ir_ready;
   logic        err;

   ifetch_queue #(.DEPTH(DEPTH), .INITIAL_IA(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_ia    (redirect_ia),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .ir_valid       (ir_valid),
      .ir             (ir),
      .ia_plus_4      (ia_plus_4),
      .ir_ready       (ir_ready),
      .err            (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] acc_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          n_pop = 0;
   bit          imem_en = 1'b0;
   bit          chk_stream = 1'b0;
   logic [31:0] exp_next = 32'h0;
   logic [31:0] first_acc;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge+1, record acceptance, drive IMEM at next negedge
   task automatic step();
      logic        acc;
      logic [31:0] aa;
      pend_t       p;
      #1;
      acc = req_valid && req_ready;
      aa  = req_addr;
      if (chk_stream && ir_valid && ir_ready && !redirect_valid && !rst) begin
         check("stream_ia", ia_plus_4, exp_next);
         check("stream_ir", ir, word(exp_next - 32'd4));
         exp_next = exp_next + 32'd4;
         n_pop++;
      end
      @(posedge clk);
      cyc++;
      if (acc) begin
         p.addr = aa;
         p.due  = cyc + lat - 1;
         pend.push_back(p);
         acc_q.push_back(aa);
      end
      @(negedge clk);
      if (imem_en) begin
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
         end
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      resp_valid     = 1'b0;
      resp_data      = '0;
      chk_stream     = 1'b0;
      pend.delete();
      step();
      step();
      pend.delete();
      acc_q.delete();
      resp_valid = 1'b0;
      rst        = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_ia    = '0;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_data      = '0;
      ir_ready       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_ir_valid",  32'(ir_valid),  32'd0);
      check("rst_ir",        ir,             32'd0);
      check("rst_ia_plus_4", ia_plus_4,      32'd0);
      check("rst_err",       32'(err),       32'd0);
      check("rst_req_addr",  req_addr,       32'd0);
      @(negedge clk);

      // Streaming, 1-cycle IMEM
      lat = 1; imem_en = 1'b1; req_ready = 1'b1; ir_ready = 1'b1;
      chk_stream = 1'b1; exp_next = 32'd4; n_pop = 0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (i == 0) check("stream_first_req", 32'(req_valid), 32'd1);
         check("stream_latency", 32'(ir_valid), 32'(i == 2));
         step();
      end
      for (int i = 0; i < 16; i++) begin
         #1 check("stream_no_bubble", 32'(ir_valid), 32'd1);
         step();
      end
      check("stream_pops", 32'(n_pop), 32'd17);

      // Stall fill and single pop
      do_reset();
      lat = 1; ir_ready = 1'b0; req_ready = 1'b1;
      repeat (8) step();
      #1;
      check("fill_nreq",      32'(acc_q.size()), 32'd4);
      first_acc = (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF;
      check("fill_first_req", first_acc, 32'h0);
      first_acc = (acc_q.size() > 3) ? acc_q[3] : 32'hDEAD_BEEF;
      check("fill_last_req",  first_acc, 32'hC);
      check("fill_req_valid", 32'(req_valid), 32'd0);
      check("fill_ir_valid",  32'(ir_valid),  32'd1);
      check("fill_ir",        ir,        word(32'h0));
      check("fill_ia",        ia_plus_4, 32'h4);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      repeat (5) step();
      #1;
      check("refill_nreq", 32'(acc_q.size()), 32'd5);
      first_acc = (acc_q.size() > 4) ? acc_q[4] : 32'hDEAD_BEEF;
      check("refill_req",  first_acc, 32'h10);
      check("refill_req_valid", 32'(req_valid), 32'd0);
      check("refill_ir",   ir,        word(32'h4));
      check("refill_ia",   ia_plus_4, 32'h8);

      // Redirect with two requests outstanding
      do_reset();
      lat = 3; ir_ready = 1'b0; req_ready = 1'b1;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_ia    = 32'h103;
      #1 check("redir_req_block", 32'(req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      acc_q.delete();
      ir_ready = 1'b1; chk_stream = 1'b1; exp_next = 32'h104; n_pop = 0;
      #1;
      check("redir_flush",    32'(ir_valid), 32'd0);
      check("redir_req_addr", req_addr, 32'h100);
      repeat (12) step();
      first_acc = (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF;
      check("redir_first_req", first_acc, 32'h100);
      check("redir_pops", 32'(n_pop >= 3), 32'd1);

      // Redirect coincident with a response and a pop
      do_reset();
      lat = 2; ir_ready = 1'b1; req_ready = 1'b1;
      chk_stream = 1'b1; exp_next = 32'd4; n_pop = 0;
      repeat (6) step();
      #1 check("redir2_pre_valid", 32'(ir_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_ia    = 32'h200;
      step();
      redirect_valid = 1'b0;
      exp_next = 32'h204; n_pop = 0;
      #1 check("redir2_flush", 32'(ir_valid), 32'd0);
      repeat (10) step();
      check("redir2_pops", 32'(n_pop >= 3), 32'd1);

      // Wrap-around with 3-cycle IMEM and random stalls
      do_reset();
      lat = 3; req_ready = 1'b1;
      chk_stream = 1'b1; exp_next = 32'd4; n_pop = 0;
      for (int i = 0; i < 3000 && n_pop < 100; i++) begin
         ir_ready = 1'($urandom_range(0, 1));
         step();
      end
      check("wrap_count", 32'(n_pop >= 100), 32'd1);

      // Spurious response, then asynchronous reset during traffic
      do_reset();
      imem_en = 1'b0; req_ready = 1'b0; ir_ready = 1'b0;
      resp_valid = 1'b1;
      resp_data  = 32'hBAD0_BAD0;
      step();
      resp_valid = 1'b0;
      #1;
      check("spur_err",      32'(err),      32'd1);
      check("spur_ir_valid", 32'(ir_valid), 32'd0);
      step();
      step();
      #1;
      check("spur_err_sticky", 32'(err),      32'd1);
      check("spur_ir_valid2",  32'(ir_valid), 32'd0);
      imem_en = 1'b1; req_ready = 1'b1; lat = 1;
      repeat (5) step();
      #1 check("arst_pre_valid", 32'(ir_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_req_valid", 32'(req_valid), 32'd0);
      check("arst_ir_valid",  32'(ir_valid),  32'd0);
      check("arst_ir",        ir,             32'd0);
      check("arst_ia_plus_4", ia_plus_4,      32'd0);
      check("arst_err",       32'(err),       32'd0);
      check("arst_req_addr",  req_addr,       32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 Parameter INITIAL_IA, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 redirect_valid  input  1  branch/jump redirect request from EX.
REQ-007 redirect_ia  input  32  redirect target address; bits [1:0] ignored and treated as 0.
REQ-008 req_valid  output  1  IMEM fetch request valid.
REQ-009 req_addr  output  32  IMEM fetch address, word aligned.
REQ-010 req_ready  input  1  IMEM accepts the request this cycle.
REQ-011 resp_valid  input  1  IMEM returns one word, in request order, at least 1 cycle after acceptance.
REQ-012 resp_data  input  32  returned instruction word.
REQ-013 ir_valid  output  1  queue head holds a valid instruction.
REQ-014 ir  output  32  head instruction word.
REQ-015 ia_plus_4  output  32  head instruction address + 4.
REQ-016 ir_ready  input  1  IF/ID consumes the head this cycle (low = stall).
REQ-017 err  output  1  sticky: a response arrived with no request outstanding.

Function
REQ-018 fetch_ia register SHALL hold the next request address; an accepted request (req_valid && req_ready) SHALL advance fetch_ia by 4 (mod 2^32).
REQ-019 req_addr SHALL equal fetch_ia combinationally.
REQ-020 credit = DEPTH - occupancy - outstanding; req_valid SHALL be (credit > 0) && !redirect_valid && !rst.
REQ-021 outstanding SHALL increment on acceptance, decrement on resp_valid, and remain unchanged when both occur in the same cycle; width clog2(DEPTH)+1.
REQ-022 Each request SHALL record its address; the entry pushed SHALL hold {resp_data, request address + 4}, in order.
REQ-023 resp_valid with discard == 0 SHALL push one entry at the tail; the tail pointer wraps modulo DEPTH.
REQ-024 ir_valid && ir_ready SHALL pop the head; the head pointer wraps modulo DEPTH.
REQ-025 No bypass: a word pushed in cycle N SHALL first be visible on ir/ir_valid in cycle N+1 (fetch latency = IMEM latency + 1).
REQ-026 Simultaneous push and pop SHALL both complete, including when full or holding 1 entry; credit accounting makes overflow impossible.
REQ-027 ir and ia_plus_4 SHALL hold stable while ir_valid && !ir_ready.
REQ-028 Redirect: in the cycle redirect_valid is high, the queue SHALL be flushed (occupancy 0, pointers equal), fetch_ia SHALL load {redirect_ia[31:2],2'b00}, and discard SHALL load outstanding minus resp_valid in that cycle.
REQ-029 While discard > 0, each resp_valid SHALL decrement discard and outstanding and SHALL NOT push.
REQ-030 A pop coincident with a redirect SHALL be a no-op beyond the flush; redirect takes priority over push and pop.
REQ-031 Back-to-back redirects SHALL be supported; each recomputes discard per REQ-028, and the last target wins.
REQ-032 resp_valid when outstanding == 0 SHALL set err, SHALL NOT push, and SHALL NOT change outstanding.

Reset
REQ-033 While rst is high: fetch_ia = INITIAL_IA, occupancy = outstanding = discard = 0, both pointers = 0, err = 0.
REQ-034 While rst is high: req_valid = 0, ir_valid = 0, ir = 0, ia_plus_4 = 0.
REQ-035 Reset asserted mid-operation SHALL drop all queued and outstanding words; responses after release SHALL be treated per REQ-032.

Verification
REQ-036 Streaming: req_ready = 1, 1-cycle IMEM, ir_ready = 1 -> ir_valid from cycle 3 after release; ia_plus_4 sequence 4, 8, 12, ... with no bubbles.
REQ-037 Stall fill: ir_ready = 0, DEPTH = 4 -> exactly 4 requests issued (0x0..0xC), req_valid drops, ir = word@0x0 held; one pop -> exactly one new request to 0x10.
REQ-038 Redirect with 2 outstanding to redirect_ia = 0x103 -> queue empty next cycle; next 2 responses dropped; the next request is 0x100; first ia_plus_4 = 0x104.
REQ-039 Redirect in the same cycle as a resp_valid and a pop -> that response is dropped, discard = outstanding - 1, and no stale word appears on ir.
REQ-040 Wrap-around: 3-cycle IMEM latency, ir_ready toggling randomly, 100 instructions -> ia_plus_4 strictly +4 and ir matches a memory model across pointer wraps.
REQ-041 Spurious resp_valid right after reset -> err = 1 and stays 1, ir_valid = 0; rst pulse during traffic -> all outputs at reset values asynchronously.
